// File: rtl/qam16_pkg.sv
// Shared 16-QAM definitions: 1s17 sample format, Gray 4-ASK levels, LFSR geometry.
// Used by the TX symbol source, the RX slicer and the BER checker.
package qam16_pkg;
    localparam int SAMPLE_W = 18;
    localparam int FRAC_W   = 17;
    typedef logic signed [SAMPLE_W-1:0] sample_t;

    localparam sample_t ASK_A_DEFAULT = 18'sd16384;

    localparam int LFSR_W      = 15;
    localparam int LFSR_TAP_HI = 14;
    localparam int LFSR_TAP_LO = 13;
    typedef logic [LFSR_W-1:0] lfsr_t;

    // Gray order along the amplitude axis: 00, 01, 11, 10
    typedef enum logic [1:0] {
        GRAY_M3 = 2'b00,
        GRAY_M1 = 2'b01,
        GRAY_P3 = 2'b10,
        GRAY_P1 = 2'b11
    } gray_t;

    function automatic sample_t ask_map(input logic [1:0] bits, input sample_t a);
        sample_t a3;
        a3 = a + a + a;
        ask_map = '0;
        case (gray_t'(bits))
            GRAY_M3: ask_map = -a3;
            GRAY_M1: ask_map = -a;
            GRAY_P1: ask_map = a;
            GRAY_P3: ask_map = a3;
            default: ask_map = '0;
        endcase
    endfunction
endpackage

// File: rtl/qam16_tx_symbol_source_if.sv
// Enable inputs and upsampled symbol outputs of the 16-QAM TX symbol source.
interface qam16_tx_symbol_source_if
    import qam16_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic             sam_clk_en;
    logic             sym_clk_en;
    logic             tx_en;
    sample_t          out_i;
    sample_t          out_q;
    logic             sym_valid;
    logic [3:0]       sym_bits;
    logic [CNT_W-1:0] sym_count;

    modport master (
        input  sam_clk_en, sym_clk_en, tx_en,
        output out_i, out_q, sym_valid, sym_bits, sym_count
    );

    modport slave (
        output sam_clk_en, sym_clk_en, tx_en,
        input  out_i, out_q, sym_valid, sym_bits, sym_count
    );
endinterface

// File: rtl/lfsr15_gen.sv
// 15-bit Fibonacci LFSR (x^15+x^14+1) with enable, synchronous seed load and
// recovery from the all-zero lockup state.
module lfsr15_gen
    import qam16_pkg::*;
#(
    parameter lfsr_t SEED = 15'h0001
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  en,
    input  logic  load,
    output lfsr_t state
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= SEED;
        else if (load)
            state <= SEED;
        else if (en) begin
            // all-zero is a fixed point of the feedback, so reseed instead
            if (state == '0)
                state <= SEED;
            else
                state <= {state[LFSR_W-2:0], state[LFSR_TAP_HI] ^ state[LFSR_TAP_LO]};
        end
    end
endmodule

// File: rtl/qam16_tx_symbol_source.sv
// Pseudo-random 16-QAM symbol source, Gray 4-ASK mapped per rail and
// zero-stuffed to the sample rate for the I/Q SRRC TX filters.
module qam16_tx_symbol_source
    import qam16_pkg::*;
#(
    parameter lfsr_t   LFSR_SEED = 15'h0001,
    parameter sample_t ASK_A     = ASK_A_DEFAULT,
    parameter int      CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    qam16_tx_symbol_source_if.master  bus
);
    if (3 * int'(ASK_A) > 131071) begin : g_bad_ask
        $error("qam16_tx_symbol_source: 3*ASK_A overflows 1s17");
    end
    if (LFSR_SEED == '0) begin : g_bad_seed
        $error("qam16_tx_symbol_source: LFSR_SEED must be non-zero");
    end

    lfsr_t lfsr;
    logic  sym_ev;

    assign sym_ev = bus.sam_clk_en & bus.sym_clk_en & bus.tx_en;

    lfsr15_gen #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (sym_ev),
        .load  (1'b0),
        .state (lfsr)
    );

    // Any sample instant that is not a symbol event (stuff or tx_en low) emits 0;
    // with sam_clk_en low everything holds except the one-clk sym_valid pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_i     <= '0;
            bus.out_q     <= '0;
            bus.sym_valid <= 1'b0;
            bus.sym_bits  <= '0;
            bus.sym_count <= '0;
        end else begin
            bus.sym_valid <= sym_ev;
            if (sym_ev) begin
                bus.out_i     <= ask_map(lfsr[1:0], ASK_A);
                bus.out_q     <= ask_map(lfsr[3:2], ASK_A);
                bus.sym_bits  <= lfsr[3:0];
                bus.sym_count <= bus.sym_count + CNT_W'(1);
            end else if (bus.sam_clk_en) begin
                bus.out_i <= '0;
                bus.out_q <= '0;
            end
        end
    end
endmodule
